// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants: default width, IF/ID field offsets, NOP encoding
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;

  // IF/ID packing: PC in the upper word, instruction in the lower word
  localparam int PC_LSB    = 32;
  localparam int PC_W      = 32;
  localparam int INSTR_LSB = 0;
  localparam int INSTR_W   = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [PIPE_DATA_W-1:0] pack_if_id(input logic [PC_W-1:0] pc,
                                                        input logic [INSTR_W-1:0] instr);
    return {pc, instr};
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - one-entry holding register (valid + payload) with load/unload/clear
module pipe_skid_entry #(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (unload_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with stall/flush; optional skid via PIPE_STAGE_SKID_EN
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_INSTR)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  input  logic              stall_i,
  input  logic              flush_i
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              down_rdy;
  logic              main_load;

  assign down_rdy  = ready_i & ~stall_i;
  assign main_load = ~valid_q | down_rdy;
  assign valid_o   = valid_q;
  assign data_o    = data_q;

`ifdef PIPE_STAGE_SKID_EN
  logic              accept;
  logic              skid_valid;
  logic              skid_load;
  logic              skid_unload;
  logic [DATA_W-1:0] skid_data;

  // ready depends only on skid occupancy, so no ready_i/stall_i path reaches upstream
  assign ready_o     = ~skid_valid;
  assign accept      = valid_i & ready_o;
  assign skid_load   = accept & ~main_load;
  assign skid_unload = main_load & skid_valid;

  pipe_skid_entry #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (flush_i),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (data_i),
    .valid_o  (skid_valid),
    .data_o   (skid_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q <= 1'b0;
      data_q  <= BUBBLE_VAL;
    end else if (main_load) begin
      if (skid_valid) begin
        valid_q <= 1'b1;
        data_q  <= skid_data;
      end else if (valid_i) begin
        valid_q <= 1'b1;
        data_q  <= data_i;
      end else begin
        valid_q <= 1'b0;
        data_q  <= BUBBLE_VAL;
      end
    end
  end
`else
  assign ready_o = main_load;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q <= 1'b0;
      data_q  <= BUBBLE_VAL;
    end else if (main_load) begin
      // an empty or drained slot always shows the bubble, never stale payload
      valid_q <= valid_i;
      data_q  <= valid_i ? data_i : BUBBLE_VAL;
    end
  end
`endif

endmodule
